// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and constants for the multiplier dispatcher
package mul_pkg;

    localparam int MUL_W = 4;
    localparam int TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } mul_state_e;

    function automatic int mul_timeout_cyc(input int w);
        return (1 << w) + 4;
    endfunction

    localparam int MUL_TIMEOUT_CYC = mul_timeout_cyc(MUL_W);

endpackage

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - synchronous operand FIFO, pointers wrap modulo DEPTH
module op_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_dispatcher.sv
// rtl/mul_dispatcher.sv - job front-end for the repeated-adder multiplier (optional watchdog: MUL_DISPATCH_TIMEOUT_EN)
module mul_dispatcher
    import mul_pkg::*;
#(
    parameter int W     = MUL_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic                     mul_start,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    input  logic [2*W-1:0]           mul_product,
    input  logic                     mul_done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_product,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy,
`ifdef MUL_DISPATCH_TIMEOUT_EN
    output logic                     err,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    mul_state_e       state;
    mul_state_e       state_nxt;
    logic [2*W-1:0]   fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] job_cnt;
    logic             timeout;
    logic             res_load;

    assign in_ready = !fifo_full;

    op_fifo #(.DW(2*W), .DEPTH(DEPTH)) u_op_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid && in_ready),
        .pop     (state == ISSUE),
        .wdata   ({in_a, in_b}),
        .head    (fifo_head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef MUL_DISPATCH_TIMEOUT_EN
    localparam int TO_CYC = mul_timeout_cyc(W);
    localparam int TO_W   = $clog2(TO_CYC);
    logic [TO_W-1:0] wd_cnt;

    assign timeout = (state == WAIT) && !mul_done && (wd_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == ISSUE)     wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (res_load)                       err <= !mul_done;
            else if (state == HOLD && out_ready) err <= 1'b0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign res_load = (state == WAIT) && (mul_done || timeout);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!fifo_empty) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (res_load) state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mul_start = (state == ISSUE);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
    end

    // Operands are latched on the IDLE->ISSUE step so they are already stable under the start pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_a       <= '0;
            mul_b       <= '0;
            out_product <= '0;
            out_tag     <= '0;
            job_cnt     <= '0;
        end else begin
            if (state == IDLE && !fifo_empty) {mul_a, mul_b} <= fifo_head;
            if (res_load) begin
                out_product <= mul_done ? mul_product : '0;
                out_tag     <= job_cnt;
                job_cnt     <= job_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mul_dispatcher.sv
// tb/tb_mul_dispatcher.sv - scoreboard bench for mul_dispatcher with a repeated-adder multiplier model
module tb_mul_dispatcher;

    typedef struct {
        logic [7:0] prod;
        logic [3:0] tag;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic [7:0] mul_product;
    logic       mul_done;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_product;
    logic [3:0] out_tag;
    logic       busy;
    logic [2:0] count;
`ifdef MUL_DISPATCH_TIMEOUT_EN
    logic       err;
`endif

    exp_t       sb_q[$];
    logic [7:0] op_q[$];
    logic [3:0] tb_tag = '0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_results = 0;
    logic       hang = 1'b0;
    logic       force_done = 1'b0;
    int         timer = 0;
    logic [3:0] ma = '0;
    logic [3:0] mb = '0;

    always #5 clk = ~clk;

    mul_dispatcher #(.W(4), .DEPTH(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product),
        .mul_done    (mul_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_tag     (out_tag),
        .busy        (busy),
`ifdef MUL_DISPATCH_TIMEOUT_EN
        .err         (err),
`endif
        .count       (count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Multiplier model: latency B+2 cycles after start, done/product driven on the falling edge.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer       = 0;
            mul_done    = 1'b0;
            mul_product = '0;
        end else begin
            mul_done = 1'b0;
            if (timer != 0) begin
                timer--;
                if (timer == 0 && !hang) begin
                    mul_done    = 1'b1;
                    mul_product = 8'(ma) * 8'(mb);
                end
            end
            if (mul_start) begin
                ma    = mul_a;
                mb    = mul_b;
                timer = int'(mb) + 2;
                if (op_q.size() == 0) check("start_unexpected", 1, 0);
                else begin
                    check("mul_a", mul_a, op_q[0][7:4]);
                    check("mul_b", mul_b, op_q[0][3:0]);
                    void'(op_q.pop_front());
                end
            end
            if (force_done) mul_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) check("result_unexpected", 1, 0);
            else begin
                check("out_product", out_product, sb_q[0].prod);
                check("out_tag", out_tag, sb_q[0].tag);
`ifdef MUL_DISPATCH_TIMEOUT_EN
                check("err", err, sb_q[0].err);
`endif
                void'(sb_q.pop_front());
                n_results++;
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic exp_err = 1'b0);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        e.prod = exp_err ? 8'd0 : 8'(a) * 8'(b);
        e.tag  = tb_tag;
        e.err  = exp_err;
        sb_q.push_back(e);
        op_q.push_back({a, b});
        tb_tag++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, sb_q.size(), 0);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_mul_start"}, mul_start, 0);
        check({name, "_mul_ab"}, {mul_a, mul_b}, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_product"}, out_product, 0);
        check({name, "_out_tag"}, out_tag, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_count"}, count, 0);
`ifdef MUL_DISPATCH_TIMEOUT_EN
        check({name, "_err"}, err, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int m;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset_n = 1'b1;

        // Stray done while idle must be ignored.
        @(negedge clk);
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        check("stray_done_valid", out_valid, 0);
        check("stray_done_busy", busy, 0);

        // Single job with push-to-start latency.
        push(4'd3, 4'd5);
        check("lat_count", count, 1);
        @(negedge clk);
        check("lat_start_early", mul_start, 0);
        check("lat_busy_early", busy, 0);
        @(negedge clk);
        check("lat_start", mul_start, 1);
        check("lat_busy", busy, 1);
        drain("drain_single");

        push(4'd7, 4'd0);
        push(4'd15, 4'd15);
        drain("drain_edge_ops");

        // Back-pressure: result held, nothing new issued.
        out_ready = 1'b0;
        push(4'd4, 4'd3);
        push(4'd2, 4'd5);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_product", out_product, sb_q[0].prod);
            check("bp_tag", out_tag, sb_q[0].tag);
            check("bp_no_start", mul_start, 0);
        end
        out_ready = 1'b1;
        drain("drain_bp");

        // Full FIFO with one job in flight.
        out_ready = 1'b0;
        m = n_results;
        for (int i = 0; i < 5; i++) push(4'(i + 1), 4'(i + 2));
        @(negedge clk);
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);
        check("full_busy", busy, 1);
        out_ready = 1'b1;
        push(4'd9, 4'd11);
        drain("drain_full");
        check("full_results", n_results - m, 6);

        // Reset in the middle of WAIT.
        push(4'd9, 4'd9);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mul_start && n < 50);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("midrst");
        sb_q.delete();
        op_q.delete();
        tb_tag = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push(4'd2, 4'd2);
        drain("drain_after_reset");

`ifdef MUL_DISPATCH_TIMEOUT_EN
        hang = 1'b1;
        push(4'd6, 4'd7, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mul_start && n < 50);
        m = 0;
        do begin
            @(negedge clk);
            m++;
        end while (!out_valid && m < 100);
        check("timeout_latency", m, 21);
        drain("drain_timeout");
        hang = 1'b0;
        push(4'd3, 4'd3);
        drain("drain_after_timeout");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
